// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width (5..9), parity (none/odd/even) and 1 or 2 stop bits.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around every sample point.
module uart_rx_cfg #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iRxSerial,
    output logic [DATA_BITS-1:0] oRxData,
    output logic                 oRxValid,
    output logic                 oParityErr,
    output logic                 oFrameErr,
    output logic                 oBusy
);
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    // With voting, each decision lands one count late and the next bit restarts at OFS,
    // so bit centres stay on the nominal grid.
    localparam logic [CW-1:0] START_PT  = CW'(HALF - 1 + OFS);
    localparam logic [CW-1:0] BIT_PT    = CW'(CLKS_PER_BIT - 1 + OFS);
    localparam logic [CW-1:0] CNT_RST   = CW'(OFS);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        sIDLE, sSTART, sDATA, sPARITY, sSTOP, sDONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_tick;
    logic                   w_load;
    logic                   w_bit;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_perr_acc;
    logic                   r_ferr_acc;
    logic                   r_armed;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= iRxSerial;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    assign w_bit = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
    assign w_bit = r_sync2;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= sIDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            sIDLE: begin
                if (r_armed && !r_sync2) w_state_nxt = sSTART;
            end
            sSTART: begin
                if (r_cnt == START_PT) begin
                    w_tick      = 1'b1;
                    w_state_nxt = w_bit ? sIDLE : sDATA;
                end
            end
            sDATA: begin
                if (r_cnt == BIT_PT) begin
                    w_tick = 1'b1;
                    if (r_idx == LAST_DATA) w_state_nxt = (PARITY != 0) ? sPARITY : sSTOP;
                end
            end
            sPARITY: begin
                if (r_cnt == BIT_PT) begin
                    w_tick      = 1'b1;
                    w_state_nxt = sSTOP;
                end
            end
            sSTOP: begin
                // Leave at the last stop-bit centre so a start edge half a bit later is caught.
                if (r_cnt == BIT_PT) begin
                    w_tick = 1'b1;
                    if (r_idx == LAST_STOP) begin
                        w_load      = 1'b1;
                        w_state_nxt = sDONE;
                    end
                end
            end
            sDONE:   w_state_nxt = sIDLE;
            default: w_state_nxt = sIDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_armed    <= 1'b1;
            oRxData    <= '0;
            oRxValid   <= 1'b0;
            oParityErr <= 1'b0;
            oFrameErr  <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oRxValid <= w_load;
            oBusy    <= (w_state_nxt != sIDLE);

            // A framing error disarms start detection until the line is seen high (break).
            if (w_load && (r_ferr_acc || !w_bit)) r_armed <= 1'b0;
            else if (r_sync2)                     r_armed <= 1'b1;

            if (w_load) begin
                oRxData    <= r_shift;
                oParityErr <= (PARITY != 0) && r_perr_acc;
                oFrameErr  <= r_ferr_acc | ~w_bit;
            end

            if (r_state == sIDLE) begin
                r_cnt      <= '0;
                r_idx      <= '0;
                r_par      <= 1'b0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
            end else if (w_tick) begin
                r_cnt <= CNT_RST;
                case (r_state)
                    sSTART: r_idx <= '0;
                    sDATA: begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_bit;
                        r_idx   <= (r_idx == LAST_DATA) ? 4'd0 : r_idx + 4'd1;
                    end
                    sPARITY: r_perr_acc <= r_par ^ w_bit ^ ODD_PAR;
                    sSTOP: begin
                        r_ferr_acc <= r_ferr_acc | ~w_bit;
                        r_idx      <= r_idx + 4'd1;
                    end
                    default: r_idx <= r_idx;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
